// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_seq_param_if.sv
// Request/result bundle for div_seq_param; master drives operands, slave returns results.
interface div_seq_param_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             zero;
  logic             div_by_zero;

  modport master (
    output start, signed_op, a, b,
    input  busy, done, hi, lo, zero, div_by_zero
  );

  modport slave (
    input  start, signed_op, a, b,
    output busy, done, hi, lo, zero, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring divide iteration: trial-subtract divisor from shifted partial remainder.
// Purely combinational; rem_i is the previous remainder with the next dividend bit appended.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] diff;

  // rem_i < 2*dvs_i always holds, so the borrow bit alone decides the quotient bit.
  always_comb begin
    diff  = rem_i - {1'b0, dvs_i};
    q_o   = ~diff[WIDTH];
    rem_o = q_o ? diff[WIDTH-1:0] : rem_i[WIDTH-1:0];
  end

endmodule

// File: rtl/div_seq_param.sv
// Sequential restoring divider, fixed WIDTH+2 cycle latency, start ignored while busy (no queueing).
// Signed operation is only built when DIV_SEQ_SIGNED_EN is defined; otherwise signed_op is ignored.
module div_seq_param
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  div_seq_param_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, a_q;
  logic             dbz_q;
  logic             busy_q, done_q, zero_q, dbz_out_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [WIDTH-1:0] rem_d;
  logic             q_bit_d;
  logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix;

`ifdef DIV_SEQ_SIGNED_EN
  logic a_neg, b_neg;
  logic neg_quo_q, neg_rem_q;

  always_comb begin
    a_neg = bus.signed_op & bus.a[WIDTH-1];
    b_neg = bus.signed_op & bus.b[WIDTH-1];
    a_mag = a_neg ? (~bus.a + 1'b1) : bus.a;
    b_mag = b_neg ? (~bus.b + 1'b1) : bus.b;
  end
`else
  logic signed_op_unused;
  assign signed_op_unused = bus.signed_op;

  always_comb begin
    a_mag = bus.a;
    b_mag = bus.b;
  end
`endif

  // Divide-by-zero overrides the datapath: quotient all ones, remainder is the raw dividend.
  always_comb begin
    quo_fix = quo_q;
    rem_fix = rem_q;
`ifdef DIV_SEQ_SIGNED_EN
    if (neg_quo_q) quo_fix = ~quo_q + 1'b1;
    if (neg_rem_q) rem_fix = ~rem_q + 1'b1;
`endif
    if (dbz_q) begin
      quo_fix = '1;
      rem_fix = a_q;
    end
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i ({rem_q, quo_q[WIDTH-1]}),
    .dvs_i (dvs_q),
    .rem_o (rem_d),
    .q_o   (q_bit_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      a_q       <= '0;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef DIV_SEQ_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          state_q <= CALC;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
          rem_q   <= '0;
          quo_q   <= a_mag;
          dvs_q   <= b_mag;
          a_q     <= bus.a;
          dbz_q   <= (bus.b == '0);
`ifdef DIV_SEQ_SIGNED_EN
          neg_quo_q <= a_neg ^ b_neg;
          neg_rem_q <= a_neg;
`endif
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= {quo_q[WIDTH-2:0], q_bit_d};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          quo_q   <= quo_fix;
          rem_q   <= rem_fix;
          state_q <= DONE;
        end
        DONE: begin
          lo_q      <= quo_q;
          hi_q      <= rem_q;
          zero_q    <= (quo_q == '0);
          dbz_out_q <= dbz_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_div_seq_param.sv
// Scoreboard bench for div_seq_param at WIDTH=32 and WIDTH=8; expectations follow DIV_SEQ_SIGNED_EN.
module tb_div_seq_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst32_n, rst8_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  div_seq_param_if #(.WIDTH(32)) if32 ();
  div_seq_param_if #(.WIDTH(8))  if8 ();

  div_seq_param #(.WIDTH(32)) u_div32 (.clk(clk), .rst_n(rst32_n), .bus(if32.slave));
  div_seq_param #(.WIDTH(8))  u_div8  (.clk(clk), .rst_n(rst8_n),  .bus(if8.slave));

  typedef struct {
    string       nm;
    logic [63:0] lo;
    logic [63:0] hi;
    logic        zero;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, e8;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  task automatic wait_done(int w);
    int n = 0;
    while (!(w == 32 ? if32.done : if8.done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL timeout_w%0d actual=no_done required=done", w);
    end
  endtask

  // Called at a negedge; drives start, records the accepting edge, then scrambles the inputs.
  task automatic issue(int w, string nm, bit s, logic [63:0] a, logic [63:0] b,
                       logic [63:0] elo, logic [63:0] ehi, bit ez, bit edbz, bit wdone);
    exp_t e;
    if (w == 32) begin
      if32.start = 1'b1; if32.signed_op = s; if32.a = a[31:0]; if32.b = b[31:0];
    end else begin
      if8.start = 1'b1; if8.signed_op = s; if8.a = a[7:0]; if8.b = b[7:0];
    end
    @(posedge clk);
    #1;
    e.nm = nm; e.lo = elo; e.hi = ehi; e.zero = ez; e.dbz = edbz; e.cyc = cyc + w + 2;
    if (w == 32) begin
      q32.push_back(e);
      if32.start = 1'b0; if32.signed_op = ~s; if32.a = ~a[31:0]; if32.b = '0;
    end else begin
      q8.push_back(e);
      if8.start = 1'b0; if8.signed_op = ~s; if8.a = ~a[7:0]; if8.b = '0;
    end
    @(negedge clk);
    chk({nm, ".busy"}, (w == 32) ? if32.busy : if8.busy, 64'd1);
    if (wdone) wait_done(w);
  endtask

  always @(negedge clk) begin
    if (if32.done) begin
      if (q32.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done32 actual=done required=idle cyc=%0d", cyc);
      end else begin
        e32 = q32.pop_front();
        chk({e32.nm, ".lo"},   64'(if32.lo), e32.lo);
        chk({e32.nm, ".hi"},   64'(if32.hi), e32.hi);
        chk({e32.nm, ".zero"}, 64'(if32.zero), 64'(e32.zero));
        chk({e32.nm, ".dbz"},  64'(if32.div_by_zero), 64'(e32.dbz));
        chk({e32.nm, ".cyc"},  64'(cyc), 64'(e32.cyc));
        chk({e32.nm, ".busy_end"}, 64'(if32.busy), 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (if8.done) begin
      if (q8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done8 actual=done required=idle cyc=%0d", cyc);
      end else begin
        e8 = q8.pop_front();
        chk({e8.nm, ".lo"},   64'(if8.lo), e8.lo);
        chk({e8.nm, ".hi"},   64'(if8.hi), e8.hi);
        chk({e8.nm, ".zero"}, 64'(if8.zero), 64'(e8.zero));
        chk({e8.nm, ".dbz"},  64'(if8.div_by_zero), 64'(e8.dbz));
        chk({e8.nm, ".cyc"},  64'(cyc), 64'(e8.cyc));
        chk({e8.nm, ".busy_end"}, 64'(if8.busy), 64'd0);
      end
    end
  end

  task automatic chk_zero32(string nm);
    chk({nm, ".busy"}, 64'(if32.busy), 64'd0);
    chk({nm, ".done"}, 64'(if32.done), 64'd0);
    chk({nm, ".lo"},   64'(if32.lo), 64'd0);
    chk({nm, ".hi"},   64'(if32.hi), 64'd0);
    chk({nm, ".zero"}, 64'(if32.zero), 64'd0);
    chk({nm, ".dbz"},  64'(if32.div_by_zero), 64'd0);
  endtask

  initial begin
    rst32_n = 1'b0;
    rst8_n  = 1'b0;
    if32.start = 1'b1; if32.signed_op = 1'b0; if32.a = 32'd5; if32.b = 32'd1;
    if8.start  = 1'b1; if8.signed_op  = 1'b0; if8.a  = 8'd5;  if8.b  = 8'd1;
    repeat (3) @(negedge clk);
    chk_zero32("reset32");
    chk("reset8.busy", 64'(if8.busy), 64'd0);
    chk("reset8.lo",   64'(if8.lo), 64'd0);
    chk("reset8.hi",   64'(if8.hi), 64'd0);
    if32.start = 1'b0;
    if8.start  = 1'b0;
    rst32_n = 1'b1;
    rst8_n  = 1'b1;

    // Back-to-back WIDTH=32 operations
    issue(32, "u100_7", 0, 64'd100, 64'd7, 64'd14, 64'd2, 0, 0, 1);
`ifdef DIV_SEQ_SIGNED_EN
    issue(32, "s_m100_7", 1, 64'hFFFFFF9C, 64'd7, 64'hFFFFFFF2, 64'hFFFFFFFE, 0, 0, 1);
    issue(32, "s_100_m7", 1, 64'd100, 64'hFFFFFFF9, 64'hFFFFFFF2, 64'd2, 0, 0, 1);
    issue(32, "s_m10_2",  1, 64'hFFFFFFF6, 64'd2, 64'hFFFFFFFB, 64'd0, 0, 0, 1);
`else
    issue(32, "s_m100_7", 1, 64'hFFFFFF9C, 64'd7, 64'h24924916, 64'd2, 0, 0, 1);
    issue(32, "s_100_m7", 1, 64'd100, 64'hFFFFFFF9, 64'd0, 64'd100, 1, 0, 1);
    issue(32, "s_m10_2",  1, 64'hFFFFFFF6, 64'd2, 64'h7FFFFFFB, 64'd0, 0, 0, 1);
`endif
    issue(32, "u_max_1", 0, 64'hFFFFFFFF, 64'd1, 64'hFFFFFFFF, 64'd0, 0, 0, 1);

    // A start pulse mid-CALC must not queue a second operation
    issue(32, "ign", 0, 64'd1000, 64'd10, 64'd100, 64'd0, 0, 0, 0);
    repeat (5) @(negedge clk);
    if32.start = 1'b1; if32.a = 32'd7; if32.b = 32'd1;
    @(negedge clk);
    if32.start = 1'b0;
    wait_done(32);
    repeat (40) @(negedge clk);

    // Reset mid-CALC discards the in-flight result; start held during reset is not taken
    issue(32, "rst_inflight", 0, 64'd100, 64'd7, 64'd14, 64'd2, 0, 0, 0);
    repeat (8) @(negedge clk);
    #2;
    rst32_n = 1'b0;
    #1;
    q32.delete();
    chk_zero32("async_rst");
    if32.start = 1'b1; if32.a = 32'd9; if32.b = 32'd3;
    repeat (40) @(negedge clk);
    chk_zero32("held_rst");
    rst32_n = 1'b1;
    issue(32, "after_rst", 0, 64'd100, 64'd7, 64'd14, 64'd2, 0, 0, 1);

    // WIDTH=8 corner cases
    issue(8, "u2a_0", 0, 64'h2A, 64'h00, 64'hFF, 64'h2A, 0, 1, 1);
    issue(8, "s2a_0", 1, 64'h2A, 64'h00, 64'hFF, 64'h2A, 0, 1, 1);
    issue(8, "s80_0", 1, 64'h80, 64'h00, 64'hFF, 64'h80, 0, 1, 1);
`ifdef DIV_SEQ_SIGNED_EN
    issue(8, "s80_ff", 1, 64'h80, 64'hFF, 64'h80, 64'h00, 0, 0, 1);
    issue(8, "s_m7_2", 1, 64'hF9, 64'h02, 64'hFD, 64'hFF, 0, 0, 1);
`else
    issue(8, "s80_ff", 1, 64'h80, 64'hFF, 64'h00, 64'h80, 1, 0, 1);
    issue(8, "s_m7_2", 1, 64'hF9, 64'h02, 64'h7C, 64'h01, 0, 0, 1);
`endif
    issue(8, "u3_9", 0, 64'd3, 64'd9, 64'd0, 64'd3, 1, 0, 1);

    repeat (20) @(negedge clk);
    checks++;
    if (q32.size() + q8.size() != 0) begin
      failures++;
      $display("FAIL pending_results actual=%0d required=0", q32.size() + q8.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_seq_param.md
DIV_SEQ_PARAM -- requirements
Module: div_seq_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal 4..64).
REQ-002 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port signed_op  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
REQ-006 SHALL have port a  input  WIDTH  dividend; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  divisor; sampled with start.
REQ-008 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse when hi/lo are updated.
REQ-010 SHALL have port hi  output  WIDTH  remainder.
REQ-011 SHALL have port lo  output  WIDTH  quotient.
REQ-012 SHALL have port zero  output  1  quotient equals zero; updated with hi/lo.
REQ-013 SHALL have port div_by_zero  output  1  sampled b was zero; updated with hi/lo.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX, DONE; IDLE->CALC on start, CALC->FIX after WIDTH iterations, FIX->DONE, DONE->IDLE unconditionally.
REQ-015 SHALL latch a, b, signed_op on the accepting edge; input changes afterwards SHALL not affect the result.
REQ-016 SHALL ignore start in CALC, FIX, DONE (no queueing).
REQ-017 SHALL perform one restoring shift-compare-subtract iteration per CALC cycle on a 2*WIDTH remainder/quotient register, using operand magnitudes.
REQ-018 SHALL assert done exactly WIDTH+2 cycles after the accepting edge (WIDTH CALC + FIX + DONE), independent of operand values.
REQ-019 SHALL in FIX negate the quotient when signed and operand signs differ, and negate the remainder when signed and a is negative (remainder sign follows dividend).
REQ-020 SHALL update hi, lo, zero, div_by_zero only on the DONE cycle and hold them until the next DONE.
REQ-021 SHALL on b==0 produce lo = all ones, hi = a (unmodified), div_by_zero = 1, same latency.
REQ-022 SHALL on signed overflow (a = most-negative, b = -1) produce lo = most-negative, hi = 0, div_by_zero = 0.
REQ-023 SHALL accept start in the IDLE cycle directly following DONE (back-to-back throughput WIDTH+3 cycles).

Reset
REQ-024 SHALL on rst_n low, asynchronously, enter IDLE and clear busy, done, hi, lo, zero, div_by_zero to 0, also mid-operation; in-flight result SHALL be discarded.
REQ-025 SHALL accept no start while rst_n is low; first acceptance is the first rising edge with rst_n high.

Configuration
REQ-026 SHALL support macro DIV_SEQ_SIGNED_EN: defined -> signed_op honoured per REQ-019/REQ-022; undefined -> signed_op port present but treated as 0, negation logic not synthesised.

Structure
REQ-027 SHALL take state enum typedef (div_state_t) and state encodings from shared package div_pkg.
REQ-028 SHALL place one combinational iteration in sub-module div_step (inputs: partial remainder, divisor magnitude; outputs: next remainder, quotient bit), parameterised by WIDTH.

Verification
REQ-029 WIDTH=32, unsigned, a=100, b=7 -> done at cycle 34 after start; lo=14, hi=2, zero=0.
REQ-030 WIDTH=32, signed, a=-100, b=7 -> lo=-14, hi=-2; a=100, b=-7 -> lo=-14, hi=2.
REQ-031 WIDTH=8, a=0x2A, b=0 (both modes) -> lo=0xFF, hi=0x2A, div_by_zero=1, done at cycle 10.
REQ-032 WIDTH=8, signed, a=0x80, b=0xFF -> lo=0x80, hi=0x00; unsigned, a=3, b=9 -> lo=0, zero=1, hi=3.
REQ-033 start pulsed during CALC and rst_n dropped mid-CALC -> second start ignored; after reset all outputs 0, FIX/DONE never reached, next start completes normally.
REQ-034 DIV_SEQ_SIGNED_EN undefined, signed_op=1, a=0xFFFFFFF6, b=2 -> unsigned result lo=0x7FFFFFFB, hi=0.
